// File: rtl/multi_cycle_shifter.sv
// multi_cycle_shifter: iterative logical/arithmetic/rotate shifter with start/busy/done handshake.
// Define MULTI_CYCLE_SHIFTER_BARREL_EN for a single-cycle barrel-shifter variant.
module multi_cycle_shifter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] inp,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
    state_t state, state_nx;

    // Shift by s positions; rotate uses s mod WIDTH, shifts of s >= WIDTH flush or sign-fill.
    function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d, input logic dr,
                                                   input logic [1:0] md, input int s);
        int k;
        k = s % WIDTH;
        if (md == 2'b10)
            shift_by = dr ? (d >> k) | (d << (WIDTH - k)) : (d << k) | (d >> (WIDTH - k));
        else if (md == 2'b01 && dr)
            shift_by = $signed(d) >>> s;
        else
            shift_by = dr ? d >> s : d << s;
    endfunction

    assign busy = state == S_SHIFT;
    assign done = state == S_DONE;

`ifdef MULTI_CYCLE_SHIFTER_BARREL_EN
    function automatic logic [WIDTH-1:0] barrel(input logic [WIDTH-1:0] d, input logic dr,
                                                 input logic [1:0] md, input logic [CNT_W-1:0] c);
        barrel = d;
        for (int k = 0; k < CNT_W; k++)
            if (c[k]) barrel = shift_by(barrel, dr, md, 1 << k);
    endfunction

    always_comb state_nx = start ? S_DONE : S_IDLE;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= S_IDLE;
            out   <= '0;
        end else begin
            state <= state_nx;
            if (start) out <= barrel(inp, dir, mode, cnt);
        end
`else
    logic [WIDTH-1:0] data, data_nx;
    logic [CNT_W-1:0] counter;
    logic             dir_q;
    logic [1:0]       mode_q;
    logic             last;

    assign data_nx = shift_by(data, dir_q, mode_q, 1);
    assign last    = counter == CNT_W'(1);

    always_comb
        state_nx = state == S_SHIFT ? (last ? S_DONE : S_SHIFT)
                                    : (start ? (cnt == '0 ? S_DONE : S_SHIFT) : S_IDLE);

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state   <= S_IDLE;
            out     <= '0;
            data    <= '0;
            counter <= '0;
            dir_q   <= 1'b0;
            mode_q  <= 2'b00;
        end else begin
            state <= state_nx;
            if (state == S_SHIFT) begin
                data    <= data_nx;
                counter <= counter - CNT_W'(1);
                if (last) out <= data_nx;
            end else if (start) begin
                dir_q  <= dir;
                mode_q <= mode;
                if (cnt == '0) out <= inp;
                else begin
                    data    <= inp;
                    counter <= cnt;
                end
            end
        end
`endif
endmodule

// File: tb/tb_multi_cycle_shifter.sv
// tb_multi_cycle_shifter: scoreboard bench for multi_cycle_shifter (WIDTH=8, CNT_W=3).
module tb_multi_cycle_shifter;
`ifdef MULTI_CYCLE_SHIFTER_BARREL_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] inp = '0;
    logic       dir = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [2:0] cnt = '0;
    logic       busy, done;
    logic [7:0] out;

    typedef struct {
        logic [7:0] val;
        int         lat;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    multi_cycle_shifter #(.WIDTH(8), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .inp(inp), .dir(dir),
        .mode(mode), .cnt(cnt), .busy(busy), .done(done), .out(out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model(input logic [7:0] d, input logic dr, input logic [1:0] m, input int c);
        for (int i = 0; i < c; i++)
            d = dr ? {(m == 2'b10) ? d[0] : (m == 2'b01) ? d[7] : 1'b0, d[6:0] >> 0 == d[6:0] ? d[7:1] : d[7:1]}
                   : {d[6:0], (m == 2'b10) ? d[7] : 1'b0};
        return d;
    endfunction

    // Caller must be positioned before a rising edge (normally at a falling edge).
    task automatic issue(input logic [7:0] i, input logic dr, input logic [1:0] m, input logic [2:0] c,
                         input logic [7:0] expv);
        exp_t e;
        inp = i; dir = dr; mode = m; cnt = c; start = 1'b1;
        @(posedge clk);
        e.val = expv;
        e.lat = BARREL ? 1 : int'(c) + 1;
        sb.push_back(e);
    endtask

    // Leaves the bench at the falling edge where done was seen.
    task automatic wait_done(input string name, input bit noise);
        exp_t e;
        int   n = 0;
        forever begin
            @(negedge clk);
            n++;
            start = noise && n <= 2 && !BARREL;
            if (noise) begin inp = 8'h5A; cnt = 3'd0; end
            if (done) break;
            checks++;
            if (busy !== !BARREL) begin
                errors++;
                $display("FAIL %s busy: got %b want %b (cycle %0d)", name, busy, !BARREL, n);
            end
            if (n > 20) begin
                errors++;
                $display("FAIL %s timeout: no done after %0d cycles", name, n);
                void'(sb.pop_front());
                return;
            end
        end
        start = 1'b0;
        e = sb.pop_front();
        checks += 3;
        if (n != e.lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, n, e.lat);
        end
        if (out !== e.val) begin
            errors++;
            $display("FAIL %s out: got %h want %h", name, out, e.val);
        end
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_at_done: got %b want 0", name, busy);
        end
    endtask

    task automatic run_op(input string name, input logic [7:0] i, input logic dr, input logic [1:0] m,
                          input logic [2:0] c, input logic [7:0] expv);
        @(negedge clk);
        issue(i, dr, m, c, expv);
        wait_done(name, 1'b0);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            start = 1'($urandom); inp = 8'($urandom); cnt = 3'($urandom);
            dir = 1'($urandom); mode = 2'($urandom);
            #1;
            checks++;
            if (out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: got out=%h busy=%b done=%b want 00/0/0", out, busy, done);
            end
        end
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_no_done: got done=%b busy=%b want 0/0", done, busy);
            end
        end
    endtask

    task automatic test_logical_left;
        run_op("lsl3", 8'h0B, 1'b0, 2'b00, 3'd3, 8'h58);
    endtask

    task automatic test_arith_right;
        run_op("asr2", 8'h90, 1'b1, 2'b01, 3'd2, 8'hE4);
        run_op("asr7", 8'h90, 1'b1, 2'b01, 3'd7, 8'hFF);
        run_op("lsr7", 8'h90, 1'b1, 2'b00, 3'd7, 8'h01);
        run_op("lsl7", 8'hFF, 1'b0, 2'b01, 3'd7, 8'h80);
    endtask

    task automatic test_rotate;
        run_op("rol1", 8'h81, 1'b0, 2'b10, 3'd1, 8'h03);
        run_op("ror4", 8'h81, 1'b1, 2'b10, 3'd4, 8'h18);
        run_op("rol7", 8'h81, 1'b0, 2'b10, 3'd7, 8'hC0);
        run_op("ror7", 8'h2D, 1'b1, 2'b10, 3'd7, 8'h5A);
    endtask

    task automatic test_cnt_zero;
        run_op("pass", 8'hA5, 1'b1, 2'b01, 3'd0, 8'hA5);
    endtask

    task automatic test_start_in_shift;
        @(negedge clk);
        issue(8'h03, 1'b0, 2'b00, 3'd5, 8'h60);
        wait_done("shift_ignore", 1'b1);
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        issue(8'h11, 1'b0, 2'b00, 3'd3, 8'h88);
        wait_done("b2b_a", 1'b0);
        issue(8'h3C, 1'b1, 2'b00, 3'd0, 8'h3C);
        wait_done("b2b_b", 1'b0);
        issue(8'hC1, 1'b1, 2'b10, 3'd4, 8'h1C);
        wait_done("b2b_c", 1'b0);
    endtask

    task automatic test_reset_mid_shift;
        @(negedge clk);
        issue(8'h7F, 1'b0, 2'b10, 3'd6, 8'hDF);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        void'(sb.pop_front());
        checks++;
        if (out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_shift: got out=%h busy=%b done=%b want 00/0/0", out, busy, done);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (8) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || out !== 8'h00) begin
                errors++;
                $display("FAIL post_rst_quiet: got done=%b out=%h want 0/00", done, out);
            end
        end
    endtask

    task automatic test_random;
        logic [7:0] i;
        logic       dr;
        logic [1:0] m;
        logic [2:0] c;
        repeat (24) begin
            i = 8'($urandom); dr = 1'($urandom); m = 2'($urandom); c = 3'($urandom);
            run_op("random", i, dr, m, c, model(i, dr, m, int'(c)));
        end
    endtask

    initial begin
        test_reset();
        test_logical_left();
        test_arith_right();
        test_rotate();
        test_cnt_zero();
        test_start_in_shift();
        test_back_to_back();
        test_reset_mid_shift();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
